circuit1_scheduler: RTL and testbench
=====================================

CIRCUIT1_SCHEDULER -- requirements
Module: circuit1_scheduler

Interface
REQ-001 SHALL have ports Clk input 1, rising-edge clock.
REQ-002 SHALL have port Rst input 1, asynchronous active-low reset (0 = reset).
REQ-003 SHALL have port Start input 1, request to compute one result set.
REQ-004 SHALL have ports a, b, c input 8 each, unsigned operands, sampled only on the accepting edge.
REQ-005 SHALL have port Busy output 1, high while an operation is in progress.
REQ-006 SHALL have port Done output 1, one-cycle completion pulse.
REQ-007 SHALL have port z output 8, registered result.
REQ-008 SHALL have port x output 16, registered result.

Function
REQ-009 SHALL implement one clock, with reset asynchronous and active-low.
REQ-010 SHALL compute, over multiple cycles, the following values, all unsigned and wrapping:
- d = (a+b) mod 2^8
- e = (a+c) mod 2^8
- z = d if d >= e, else e
- f = a*c, 16-bit, zero-extended operands
- x = (f - {8'b0,d}) mod 2^16
REQ-011 SHALL use exactly one 8-bit adder, time-shared between d and e through state-controlled operand muxes, plus one comparator, one 16-bit multiplier and one 16-bit subtractor.
REQ-012 SHALL implement the FSM states IDLE, S_ADD_D, S_ADD_E, S_CMP_MUL and S_SUB; the encoding is free.
REQ-013 In IDLE with Start=1 at a rising edge, SHALL capture a, b, c into internal registers and move to S_ADD_D; in IDLE with Start=0, SHALL stay in IDLE.
REQ-014 SHALL make these transitions:
- S_ADD_D registers d, then -> S_ADD_E.
- S_ADD_E registers e, then -> S_CMP_MUL.
- S_CMP_MUL registers the z candidate and f, then -> S_SUB.
- S_SUB computes x, then -> IDLE.
REQ-015 On the S_SUB -> IDLE edge, SHALL update z and x simultaneously and set Done=1 for exactly the following cycle.
REQ-016 Latency: capture at edge k SHALL give z/x valid and Done=1 in the cycle after edge k+4.
REQ-017 SHALL hold z and x stable between completions; they change only on a completion edge or on reset.
REQ-018 SHALL drive Busy=1 whenever the state is not IDLE, and Busy=0 in IDLE, including the Done cycle.
REQ-019 SHALL ignore Start while Busy=1; inputs a/b/c SHALL NOT affect the computation in flight.
REQ-020 SHALL accept Start during the Done cycle (state IDLE), giving back-to-back throughput of one result per 5 cycles.
REQ-021 When d == e, SHALL select z = d.
REQ-022 SHALL wrap x on underflow (f < d) modulo 2^16, with no flag.

Reset
REQ-023 On Rst=0, SHALL immediately and asynchronously force the state to IDLE and clear z=0, x=0, Done=0, Busy=0 and all internal d/e/f/operand registers to 0.
REQ-024 Reset during any non-IDLE state SHALL abort the operation: no Done pulse, and outputs remain 0.
REQ-025 Start SHALL be honoured on the first rising edge with Rst=1.

Verification
REQ-026 Reset test: assert Rst=0 mid-cycle -> z=0x00, x=0x0000, Done=0, Busy=0 without waiting for Clk.
REQ-027 Basic test: a=10, b=20, c=5, Start pulse -> d=30, e=15, z=30 (0x1E), x=20 (0x0014); Done high exactly 4 edges after capture; Busy high for 4 cycles.
REQ-028 Wrap test: a=200, b=100, c=3 -> d=44, e=203, z=203 (0xCB), f=600, x=556 (0x022C).
REQ-029 Underflow/tie tests: a=0, b=3, c=9 -> z=9, x=0xFFFD; then a=5, b=7, c=7 -> z=12 (d==e), x=23 (0x0017).
REQ-030 Handshake test: hold Start=1 continuously with changing inputs -> one Done every 5 cycles; each result matches the inputs captured on that run's accept edge; inputs toggled while Busy have no effect.
REQ-031 Abort test: drop Rst to 0 while in S_ADD_E -> immediate IDLE, outputs 0, no Done; release Rst, Start with a=1, b=1, c=1 -> z=2, x=0xFFFF.

Source files
------------

// File: rtl/circuit1_scheduler.sv
// rtl/circuit1_scheduler.sv - multi-cycle scheduler computing z = max(a+b, a+c) and x = a*c - (a+b)
module circuit1_scheduler (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [7:0]  c,
    output logic        Busy,
    output logic        Done,
    output logic [7:0]  z,
    output logic [15:0] x
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        S_ADD_D   = 3'd1,
        S_ADD_E   = 3'd2,
        S_CMP_MUL = 3'd3,
        S_SUB     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, b_q, c_q;
    logic [7:0]  d_q, e_q, zc_q;
    logic [15:0] f_q;
    logic [7:0]  z_q;
    logic [15:0] x_q;
    logic        done_q;

    logic        capture;
    logic [7:0]  add_rhs;
    logic [7:0]  add_sum;
    logic [7:0]  cmp_max;
    logic [15:0] mul_prod;
    logic [15:0] sub_diff;

    // Single shared adder: right operand is b while forming d, c while forming e.
    always_comb begin
        add_rhs  = (state_q == S_ADD_E) ? c_q : b_q;
        add_sum  = a_q + add_rhs;
        cmp_max  = (d_q >= e_q) ? d_q : e_q;
        mul_prod = {8'h00, a_q} * {8'h00, c_q};
        sub_diff = f_q - {8'h00, d_q};
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    capture = 1'b1;
                    state_d = S_ADD_D;
                end
            end
            S_ADD_D:   state_d = S_ADD_E;
            S_ADD_E:   state_d = S_CMP_MUL;
            S_CMP_MUL: state_d = S_SUB;
            S_SUB:     state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            c_q     <= 8'h00;
            d_q     <= 8'h00;
            e_q     <= 8'h00;
            zc_q    <= 8'h00;
            f_q     <= 16'h0000;
            z_q     <= 8'h00;
            x_q     <= 16'h0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_SUB);
            if (capture) begin
                a_q <= a;
                b_q <= b;
                c_q <= c;
            end
            if (state_q == S_ADD_D) begin
                d_q <= add_sum;
            end
            if (state_q == S_ADD_E) begin
                e_q <= add_sum;
            end
            if (state_q == S_CMP_MUL) begin
                zc_q <= cmp_max;
                f_q  <= mul_prod;
            end
            // Both results are published together on the completion edge.
            if (state_q == S_SUB) begin
                z_q <= zc_q;
                x_q <= sub_diff;
            end
        end
    end

    assign Busy = (state_q != IDLE);
    assign Done = done_q;
    assign z    = z_q;
    assign x    = x_q;

endmodule

// File: tb/tb_circuit1_scheduler.sv
// tb/tb_circuit1_scheduler.sv - randomized self-checking bench with behavioural model for circuit1_scheduler
module tb_circuit1_scheduler;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic [7:0]  a, b, c;
    logic        Busy;
    logic        Done;
    logic [7:0]  z;
    logic [15:0] x;

    int checks;
    int errors;
    int done_seen;

    int          m_left;
    logic [7:0]  m_a, m_b, m_c;
    logic [7:0]  m_z;
    logic [15:0] m_x;
    logic        m_done;

    circuit1_scheduler dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .a     (a),
        .b     (b),
        .c     (c),
        .Busy  (Busy),
        .Done  (Done),
        .z     (z),
        .x     (x)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [7:0] ref_z(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic);
        int d, e;
        d = (int'(ia) + int'(ib)) % 256;
        e = (int'(ia) + int'(ic)) % 256;
        return (d >= e) ? 8'(d) : 8'(e);
    endfunction

    function automatic logic [15:0] ref_x(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic);
        int d, f;
        d = (int'(ia) + int'(ib)) % 256;
        f = int'(ia) * int'(ic);
        return 16'((f - d + 65536) % 65536);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_left = 0;
        m_a = 8'h00; m_b = 8'h00; m_c = 8'h00;
        m_z = 8'h00; m_x = 16'h0000; m_done = 1'b0;
    endtask

    // Model: a countdown of remaining busy cycles; results land when it reaches zero.
    task automatic model_edge();
        if (!Rst) return;
        m_done = 1'b0;
        if (m_left == 0) begin
            if (Start) begin
                m_a = a; m_b = b; m_c = c;
                m_left = 4;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_z = ref_z(m_a, m_b, m_c);
                m_x = ref_x(m_a, m_b, m_c);
                m_done = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        chk("busy", 32'(Busy), 32'(m_left != 0));
        chk("done", 32'(Done), 32'(m_done));
        chk("z",    32'(z),    32'(m_z));
        chk("x",    32'(x),    32'(m_x));
        if (Done) done_seen++;
    endtask

    task automatic step(input logic st, input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic);
        Start = st; a = ia; b = ib; c = ic;
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        compare_all();
    endtask

    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic);
        step(1'b1, ia, ib, ic);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        chk("op_done_pulse", 32'(Done), 32'd1);
    endtask

    task automatic reset_mid_cycle();
        #2;
        Rst = 1'b0;
        #1;
        model_clear();
        chk("rst_z",    32'(z),    32'h00);
        chk("rst_x",    32'(x),    32'h0000);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        @(negedge Clk);
        compare_all();
        Rst = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0; done_seen = 0;
        Rst = 1'b0; Start = 1'b0; a = 8'h00; b = 8'h00; c = 8'h00;
        model_clear();

        chk("model_basic_z", 32'(ref_z(8'd10, 8'd20, 8'd5)), 32'd30);
        chk("model_basic_x", 32'(ref_x(8'd10, 8'd20, 8'd5)), 32'd20);
        chk("model_wrap_x",  32'(ref_x(8'd200, 8'd100, 8'd3)), 32'h022C);
        chk("model_tie_z",   32'(ref_z(8'd5, 8'd7, 8'd7)), 32'd12);

        @(negedge Clk);
        @(negedge Clk);
        compare_all();
        Rst = 1'b1;

        run_op(8'd10, 8'd20, 8'd5);
        chk("basic_z", 32'(z), 32'h1E);
        chk("basic_x", 32'(x), 32'h0014);
        step(1'b0, 8'd0, 8'd0, 8'd0);
        chk("basic_hold_z", 32'(z), 32'h1E);

        run_op(8'd200, 8'd100, 8'd3);
        chk("wrap_z", 32'(z), 32'hCB);
        chk("wrap_x", 32'(x), 32'h022C);

        run_op(8'd0, 8'd3, 8'd9);
        chk("under_z", 32'(z), 32'h09);
        chk("under_x", 32'(x), 32'hFFFD);

        run_op(8'd5, 8'd7, 8'd7);
        chk("tie_z", 32'(z), 32'd12);
        chk("tie_x", 32'(x), 32'h0017);

        // Start held high: back-to-back accepts including on each Done cycle.
        step(1'b0, 8'd0, 8'd0, 8'd0);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        chk("handshake_dones", 32'(done_seen), 32'd4);

        // Abort in S_ADD_E: capture edge, one more edge, then reset.
        step(1'b0, 8'd0, 8'd0, 8'd0);
        step(1'b0, 8'd0, 8'd0, 8'd0);
        step(1'b0, 8'd0, 8'd0, 8'd0);
        step(1'b0, 8'd0, 8'd0, 8'd0);
        step(1'b1, 8'd50, 8'd60, 8'd70);
        step(1'b0, 8'd0, 8'd0, 8'd0);
        chk("abort_busy_before", 32'(Busy), 32'd1);
        reset_mid_cycle();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'd0, 8'd0, 8'd0);
            chk("abort_no_done", 32'(Done), 32'd0);
        end
        run_op(8'd1, 8'd1, 8'd1);
        chk("post_abort_z", 32'(z), 32'd2);
        chk("post_abort_x", 32'(x), 32'hFFFF);

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
            if (i == 150) reset_mid_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
